// File: rtl/ccip_c0_rd_arbiter.sv
// ccip_c0_rd_arbiter: round-robin C0 read arbiter with per-requester outstanding tracking and response routing
module ccip_c0_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 16,
  parameter int ADDR_W    = 42
) (
  input  logic                      vl_clk_LPdomain_16ui,
  input  logic                      ffs_vl_LP32ui_lp2sy_SoftReset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      c0tx_almfull,
  output logic                      c0tx_valid,
  output logic [ADDR_W-1:0]         c0tx_addr,
  output logic [15:0]               c0tx_mdata,
  input  logic                      c0rx_rdvalid,
  input  logic [15:0]               c0rx_mdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [7:0]                rsp_tag,
  output logic                      outst_err
);
  localparam int CW = $clog2(MAX_OUTST) + 1;
  logic [CW-1:0]     cnt_q [NUM_REQ];
  logic [CW-1:0]     cnt_d [NUM_REQ];
  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [7:0]        tag_a [NUM_REQ];
  logic [1:0]        rr_q, rr_d, gnt_id, ord, rsp_id;
  logic [NUM_REQ-1:0] elig, rsp_valid_q, rsp_valid_d;
  logic              gnt_any, rsp_hit;
  logic              c0tx_valid_q, c0tx_valid_d, outst_err_q, outst_err_d;
  logic [ADDR_W-1:0] c0tx_addr_q, c0tx_addr_d;
  logic [15:0]       c0tx_mdata_q, c0tx_mdata_d;
  logic [7:0]        rsp_tag_q, rsp_tag_d;
  assign rsp_id     = c0rx_mdata[9:8];
  assign c0tx_valid = c0tx_valid_q;
  assign c0tx_addr  = c0tx_addr_q;
  assign c0tx_mdata = c0tx_mdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_tag    = rsp_tag_q;
  assign outst_err  = outst_err_q;
  always_comb begin
    rsp_hit = 1'b0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    ord     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
      tag_a[i]  = req_tag[i*8 +: 8];
      elig[i]   = ffs_vl_LP32ui_lp2sy_SoftReset_n && req_valid[i] && !c0tx_almfull
                  && cnt_q[i] < CW'(MAX_OUTST);
      if (c0rx_rdvalid && rsp_id == 2'(i) && cnt_q[i] != '0) rsp_hit = 1'b1;
    end
    // scan from farthest to nearest so the requester closest to rr wins last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      ord = 2'((32'(rr_q) + k) % NUM_REQ);
      if (elig[ord]) begin
        gnt_any = 1'b1;
        gnt_id  = ord;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]   = gnt_any && gnt_id == 2'(i);
      rsp_valid_d[i] = rsp_hit && rsp_id == 2'(i);
      cnt_d[i] = req_ready[i] == rsp_valid_d[i] ? cnt_q[i]
               : req_ready[i] ? cnt_q[i] + 1'b1 : cnt_q[i] - 1'b1;
    end
    rr_d         = gnt_any ? 2'((32'(gnt_id) + 1) % NUM_REQ) : rr_q;
    c0tx_valid_d = gnt_any;
    c0tx_addr_d  = gnt_any ? addr_a[gnt_id] : c0tx_addr_q;
    c0tx_mdata_d = gnt_any ? {6'b0, gnt_id, tag_a[gnt_id]} : c0tx_mdata_q;
    rsp_tag_d    = rsp_hit ? c0rx_mdata[7:0] : rsp_tag_q;
    outst_err_d  = outst_err_q | (c0rx_rdvalid & ~rsp_hit);
  end
  always_ff @(posedge vl_clk_LPdomain_16ui) begin
    if (!ffs_vl_LP32ui_lp2sy_SoftReset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      rr_q         <= '0;
      c0tx_valid_q <= 1'b0;
      c0tx_addr_q  <= '0;
      c0tx_mdata_q <= '0;
      rsp_valid_q  <= '0;
      rsp_tag_q    <= '0;
      outst_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      rr_q         <= rr_d;
      c0tx_valid_q <= c0tx_valid_d;
      c0tx_addr_q  <= c0tx_addr_d;
      c0tx_mdata_q <= c0tx_mdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      outst_err_q  <= outst_err_d;
    end
  end
endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// tb_ccip_c0_rd_arbiter: directed checks of arbitration, credit limits, response routing and reset
module tb_ccip_c0_rd_arbiter;
  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [4*42-1:0] req_addr;
  logic [31:0]   req_tag;
  logic [3:0]    req_ready;
  logic          almfull;
  logic          c0tx_valid;
  logic [41:0]   c0tx_addr;
  logic [15:0]   c0tx_mdata;
  logic          rdvalid;
  logic [15:0]   rx_mdata;
  logic [3:0]    rsp_valid;
  logic [7:0]    rsp_tag;
  logic          outst_err;
  int            total = 0;
  int            bad = 0;
  ccip_c0_rd_arbiter dut (
    .vl_clk_LPdomain_16ui(clk),
    .ffs_vl_LP32ui_lp2sy_SoftReset_n(rst_n),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_tag(req_tag),
    .req_ready(req_ready),
    .c0tx_almfull(almfull),
    .c0tx_valid(c0tx_valid),
    .c0tx_addr(c0tx_addr),
    .c0tx_mdata(c0tx_mdata),
    .c0rx_rdvalid(rdvalid),
    .c0rx_mdata(rx_mdata),
    .rsp_valid(rsp_valid),
    .rsp_tag(rsp_tag),
    .outst_err(outst_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    almfull = 1'b0;
    rdvalid = 1'b0;
    rx_mdata = '0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = 4'hF;
    almfull = 1'b0;
    rdvalid = 1'b0;
    rx_mdata = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*42 +: 42] = 42'(32'h100 + i);
      req_tag[i*8 +: 8] = 8'(8'h10 + i);
    end
    tick();
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_c0tx_valid", 64'(c0tx_valid), 0);
    chk("rst_c0tx_addr", 64'(c0tx_addr), 0);
    chk("rst_c0tx_mdata", 64'(c0tx_mdata), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_tag", 64'(rsp_tag), 0);
    chk("rst_err", 64'(outst_err), 0);
    // all four requesting: strict rotation 0,1,2,3,0,1,2,3
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr_c0tx_valid", 64'(c0tx_valid), 1);
        chk("rr_c0tx_mdata", 64'(c0tx_mdata), 64'((((k - 1) % 4) << 8) | (8'h10 + (k - 1) % 4)));
        chk("rr_c0tx_addr", 64'(c0tx_addr), 64'(32'h100 + (k - 1) % 4));
      end
      tick();
    end
    chk("rr_last_mdata", 64'(c0tx_mdata), 64'h0313);
    // single requester 2 round trip
    do_reset();
    req_addr[2*42 +: 42] = 42'h123;
    req_tag[2*8 +: 8] = 8'h5A;
    req_valid = 4'b0100;
    #1;
    chk("r2_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk("r2_c0tx_valid", 64'(c0tx_valid), 1);
    chk("r2_c0tx_addr", 64'(c0tx_addr), 64'h123);
    chk("r2_c0tx_mdata", 64'(c0tx_mdata), 64'h025A);
    chk("r2_cnt_one", 64'(dut.cnt_q[2]), 1);
    rdvalid = 1'b1;
    rx_mdata = 16'h025A;
    tick();
    rdvalid = 1'b0;
    chk("r2_rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("r2_rsp_tag", 64'(rsp_tag), 64'h5A);
    chk("r2_cnt_zero", 64'(dut.cnt_q[2]), 0);
    chk("r2_c0tx_idle", 64'(c0tx_valid), 0);
    chk("r2_addr_hold", 64'(c0tx_addr), 64'h123);
    chk("r2_mdata_hold", 64'(c0tx_mdata), 64'h025A);
    chk("r2_no_err", 64'(outst_err), 0);
    tick();
    chk("r2_rsp_clear", 64'(rsp_valid), 0);
    chk("r2_tag_hold", 64'(rsp_tag), 64'h5A);
    // almost-full backpressure with rr parked at 2
    do_reset();
    req_valid = 4'b0010;
    #1;
    chk("af_pre_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'hF;
    almfull = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("af_ready", 64'(req_ready), 0);
      tick();
      chk("af_c0tx_valid", 64'(c0tx_valid), 0);
    end
    almfull = 1'b0;
    #1;
    chk("af_first_grant", 64'(req_ready), 64'b0100);
    // requester 1 saturates its credit; requester 3 still served
    do_reset();
    req_valid = 4'b0010;
    for (int j = 0; j < 16; j++) begin
      #1;
      chk("sat_ready", 64'(req_ready), 64'b0010);
      tick();
    end
    chk("sat_cnt", 64'(dut.cnt_q[1]), 16);
    chk("sat_blocked", 64'(req_ready), 0);
    req_valid = 4'b1010;
    #1;
    chk("sat_other", 64'(req_ready), 64'b1000);
    tick();
    req_valid = 4'b0010;
    rdvalid = 1'b1;
    rx_mdata = 16'h0110;
    #1;
    chk("sat_still_blocked", 64'(req_ready), 0);
    tick();
    rdvalid = 1'b0;
    #1;
    chk("sat_rsp_valid", 64'(rsp_valid), 64'b0010);
    chk("sat_reopen", 64'(req_ready), 64'b0010);
    // simultaneous grant and response on requester 0, then an unmatched response
    do_reset();
    req_valid = 4'b0001;
    tick();
    chk("sim_cnt_one", 64'(dut.cnt_q[0]), 1);
    rdvalid = 1'b1;
    rx_mdata = 16'h0000;
    #1;
    chk("sim_ready", 64'(req_ready), 64'b0001);
    tick();
    chk("sim_cnt_same", 64'(dut.cnt_q[0]), 1);
    chk("sim_rsp_valid", 64'(rsp_valid), 64'b0001);
    req_valid = '0;
    rx_mdata = 16'h0100;
    tick();
    rdvalid = 1'b0;
    chk("unm_rsp_valid", 64'(rsp_valid), 0);
    chk("unm_err", 64'(outst_err), 1);
    chk("unm_cnt1", 64'(dut.cnt_q[1]), 0);
    tick();
    tick();
    chk("unm_sticky", 64'(outst_err), 1);
    // reset with outstanding reads and a pending grant
    do_reset();
    req_valid = 4'b0001;
    for (int j = 0; j < 5; j++) tick();
    chk("mr_cnt5", 64'(dut.cnt_q[0]), 5);
    rst_n = 1'b0;
    #1;
    chk("mr_ready_low", 64'(req_ready), 0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    chk("mr_c0tx_valid", 64'(c0tx_valid), 0);
    chk("mr_c0tx_addr", 64'(c0tx_addr), 0);
    chk("mr_c0tx_mdata", 64'(c0tx_mdata), 0);
    chk("mr_cnt0", 64'(dut.cnt_q[0]), 0);
    chk("mr_rr", 64'(dut.rr_q), 0);
    chk("mr_err", 64'(outst_err), 0);
    rdvalid = 1'b1;
    rx_mdata = 16'h0010;
    tick();
    rdvalid = 1'b0;
    chk("mr_late_rsp", 64'(rsp_valid), 0);
    chk("mr_late_err", 64'(outst_err), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
